// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and default frame width.
// Used by uart_tx_arbiter and uart_transmitter.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  always_comb begin
    int         j;
    logic [IW-1:0] w_j;
    j        = 0;
    w_j      = '0;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      w_j = IW'(j);
      if (!o_valid && i_req[w_j]) begin
        o_valid       = 1'b1;
        o_idx         = w_j;
        o_onehot[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one uart_transmitter among NUM_REQ clients.
// Optional WAIT watchdog: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int DATA_WIDTH_NUMBER = UART_DATA_W,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                           tx_clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_WIDTH_NUMBER-1:0] req_data,
  input  logic                           tx_done,
  output logic                           tx_start,
  output logic [DATA_WIDTH_NUMBER-1:0]   tx_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             ack,
`ifdef UART_TX_ARB_TIMEOUT_EN
  output logic                           timeout_err,
`endif
  output logic                           busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int W  = DATA_WIDTH_NUMBER;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("uart_tx_arbiter: NUM_REQ and TIMEOUT_CYCLES must be >= 2");
  end

  arb_state_t         r_state;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_idx;
  logic               r_tx_start;
  logic [W-1:0]       r_tx_data;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_onehot;
  logic [IW-1:0]      w_idx;
  logic               w_valid;
  logic [IW-1:0]      w_ptr_nxt;
  logic [W-1:0]       w_words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign w_words[g] = req_data[g*W +: W];
  end

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  assign w_ptr_nxt = (r_idx == IW'(NUM_REQ-1)) ? '0 : r_idx + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0] r_cnt;
  logic          r_tout;
  assign timeout_err = r_tout;
`endif

  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_tout     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (w_valid) begin
            r_tx_data  <= w_words[w_idx];
            r_grant    <= w_onehot;
            r_idx      <= w_idx;
            r_busy     <= 1'b1;
            r_tx_start <= 1'b1;
            r_state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_tx_start <= 1'b0;
          r_state    <= WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
          r_cnt      <= '0;
`endif
        end
        WAIT: begin
          // tx_done takes priority over a coinciding watchdog expiry
          if (tx_done) begin
            r_ack   <= r_grant;
            r_ptr   <= w_ptr_nxt;
            r_state <= ACK;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT_CYCLES-1)) begin
            r_tout  <= 1'b1;
            r_ptr   <= w_ptr_nxt;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ACK: begin
          r_ack   <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
          r_tout  <= 1'b0;
`endif
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign grant    = r_grant;
  assign ack      = r_ack;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural 8N2 serial model.
// Timeout scenario runs when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic           tx_done;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic           timeout_err;
`endif

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_ack = 0;
  logic prev_start = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ           (N),
    .DATA_WIDTH_NUMBER (W),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .tx_clk      (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .tx_done     (tx_done),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .grant       (grant),
    .ack         (ack),
`ifdef UART_TX_ARB_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .busy        (busy)
  );

  // serial transmitter model: start, 8 data LSB first, 2 stop, then done
  logic        m_busy = 1'b0;
  logic [10:0] m_sh = '1;
  logic [3:0]  m_n = '0;
  logic        m_done = 1'b0;
  logic        done_en = 1'b1;
  logic        f_done = 1'b0;
  logic        ser;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_n    <= '0;
    end else if (!m_busy) begin
      if (tx_start) begin
        m_busy <= 1'b1;
        m_sh   <= {2'b11, tx_data, 1'b0};
        m_n    <= '0;
      end
    end else if (m_n == 4'd10) begin
      m_busy <= 1'b0;
      m_done <= done_en;
    end else begin
      m_n <= m_n + 1'b1;
    end
  end

  assign ser     = m_busy ? m_sh[m_n] : 1'b1;
  assign tx_done = m_done | f_done;

  always @(posedge clk) begin
    if (ack != '0) n_ack++;
    if (tx_start) begin
      n_start++;
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL start_pulse_width: tx_start high two cycles in a row");
      end
    end
    prev_start = tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_start) begin
        ok = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: tx_start not seen within 60 cycles", nm);
    end
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_done) begin
        ok = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: tx_done not seen within 60 cycles", nm);
    end
  endtask

  // call in the cycle tx_start is visible; samples the 11 line bits
  task automatic collect(input int ci, output logic [W-1:0] b,
                         output bit frm);
    logic [10:0] bits;
    bits = '1;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (k == 0 && ci >= 0) set_word(ci, 8'hFF);
      bits[k] = ser;
    end
    b   = bits[8:1];
    frm = !bits[0] && bits[9] && bits[10];
  endtask

  task automatic test_reset();
    req = '0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({tx_start, tx_data, grant, ack, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b data=%h grant=%b ack=%b busy=%b, want all 0",
               tx_start, tx_data, grant, ack, busy);
    end
`ifdef UART_TX_ARB_TIMEOUT_EN
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_timeout_err: got %b want 0", timeout_err);
    end
`endif
    rst_n = 1'b1;
    tick();
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    tick();
    checks++;
    if (ack !== '0 || busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL idle_done_ignored: ack=%b busy=%b grant=%b, want 0/0/0",
               ack, busy, grant);
    end
  endtask

  task automatic test_single();
    int s0;
    logic [W-1:0] b;
    bit frm;
    s0 = n_start;
    set_word(2, 8'hA5);
    req = 4'b0100;
    wait_start("single_start");
    checks++;
    if (grant !== 4'b0100 || tx_data !== 8'hA5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b data=%h busy=%b, want 0100/a5/1",
               grant, tx_data, busy);
    end
    collect(-1, b, frm);
    checks++;
    if (b !== 8'hA5 || !frm) begin
      errors++;
      $display("FAIL single_serial: byte=%h framing=%0d, want a5/1", b, frm);
    end
    wait_done("single_done");
    req = '0;
    tick();
    checks++;
    if (ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_ack: got %b want 0100", ack);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || ack !== '0 || grant !== '0) begin
      errors++;
      $display("FAIL single_release: busy=%b ack=%b grant=%b, want 0", busy, ack, grant);
    end
    checks++;
    if (n_start - s0 != 1) begin
      errors++;
      $display("FAIL single_start_count: got %0d want 1", n_start - s0);
    end
  endtask

  task automatic test_fairness();
    logic [W-1:0] words [N];
    int exp;
    words[0] = 8'h10;
    words[1] = 8'h21;
    words[2] = 8'h32;
    words[3] = 8'h43;
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, words[i]);
    req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      exp = f % N;
      wait_start("fair_start");
      checks++;
      if (grant !== 4'(1 << exp) || tx_data !== words[exp]) begin
        errors++;
        $display("FAIL fair_frame%0d: grant=%b data=%h, want %b/%h",
                 f, grant, tx_data, 4'(1 << exp), words[exp]);
      end
      wait_done("fair_done");
      if (f == 7) req = '0;
    end
    tick();
    tick();
  endtask

  task automatic test_wrap();
    set_word(2, 8'h55);
    req = 4'b0100;
    wait_start("wrap_setup");
    wait_done("wrap_setup_done");
    set_word(0, 8'h0A);
    set_word(3, 8'h3B);
    req = 4'b1001;
    wait_start("wrap_first");
    checks++;
    if (grant !== 4'b1000 || tx_data !== 8'h3B) begin
      errors++;
      $display("FAIL wrap_first: grant=%b data=%h, want 1000/3b", grant, tx_data);
    end
    wait_done("wrap_first_done");
    wait_start("wrap_second");
    checks++;
    if (grant !== 4'b0001 || tx_data !== 8'h0A) begin
      errors++;
      $display("FAIL wrap_second: grant=%b data=%h, want 0001/0a", grant, tx_data);
    end
    wait_done("wrap_second_done");
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_stability();
    logic [W-1:0] b;
    bit frm;
    set_word(1, 8'h3C);
    req = 4'b0010;
    wait_start("stab_start");
    collect(1, b, frm);
    checks++;
    if (b !== 8'h3C || !frm || tx_data !== 8'h3C) begin
      errors++;
      $display("FAIL stab_serial: byte=%h framing=%0d tx_data=%h, want 3c/1/3c",
               b, frm, tx_data);
    end
    wait_done("stab_done");
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int a0;
    set_word(3, 8'h77);
    req = 4'b1000;
    wait_start("rmid_start");
    tick();
    tick();
    a0 = n_ack;
    rst_n = 1'b0;
    set_word(1, 8'h99);
    req = 4'b1010;
    tick();
    checks++;
    if ({tx_start, tx_data, grant, ack, busy} !== '0) begin
      errors++;
      $display("FAIL rmid_outputs: start=%b data=%h grant=%b ack=%b busy=%b, want all 0",
               tx_start, tx_data, grant, ack, busy);
    end
    rst_n = 1'b1;
    wait_start("rmid_regrant");
    checks++;
    if (grant !== 4'b0010 || tx_data !== 8'h99) begin
      errors++;
      $display("FAIL rmid_regrant: grant=%b data=%h, want 0010/99", grant, tx_data);
    end
    checks++;
    if (n_ack != a0) begin
      errors++;
      $display("FAIL rmid_no_ack: got %0d acks want 0", n_ack - a0);
    end
    wait_done("rmid_done");
    req = '0;
    tick();
    checks++;
    if (ack !== 4'b0010) begin
      errors++;
      $display("FAIL rmid_ack: got %b want 0010", ack);
    end
    tick();
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int a0;
    do_reset();
    done_en = 1'b0;
    set_word(0, 8'hC1);
    set_word(1, 8'hD2);
    req = 4'b0011;
    wait_start("to_start");
    a0 = n_ack;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if (timeout_err !== (i == 17)) begin
        errors++;
        $display("FAIL to_pulse: cycle %0d after start got %b want %b",
                 i, timeout_err, (i == 17));
      end
    end
    done_en = 1'b1;
    wait_start("to_next");
    checks++;
    if (grant !== 4'b0010 || tx_data !== 8'hD2) begin
      errors++;
      $display("FAIL to_next_grant: grant=%b data=%h, want 0010/d2", grant, tx_data);
    end
    checks++;
    if (n_ack != a0) begin
      errors++;
      $display("FAIL to_no_ack: got %0d acks want 0", n_ack - a0);
    end
    wait_done("to_next_done");
    req = '0;
    tick();
    checks++;
    if (ack !== 4'b0010) begin
      errors++;
      $display("FAIL to_ack: got %b want 0010", ack);
    end
    tick();
  endtask
`else
  task automatic test_wait_forever();
    done_en = 1'b0;
    set_word(0, 8'h5A);
    req = 4'b0001;
    wait_start("hold_start");
    repeat (40) tick();
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0001 || ack !== '0) begin
      errors++;
      $display("FAIL hold_wait: busy=%b grant=%b ack=%b, want 1/0001/0", busy, grant, ack);
    end
    done_en = 1'b1;
    req = '0;
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    checks++;
    if (ack !== 4'b0001) begin
      errors++;
      $display("FAIL hold_ack: got %b want 0001", ack);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_stability();
    test_reset_mid();
`ifdef UART_TX_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
